// File: rtl/mem_bus_pkg.sv
// Shared definitions for the bus-master cycle controller: operation codes,
// controller states and the default no-answer timeout.
package mem_bus_pkg;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CFG   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/bus_timeout.sv
// Saturating wait counter shared by the strobe and release phases; expired
// is high once TIMEOUT_CYCLES - 1 counted cycles have elapsed since clear.
module bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd32
) (
  input  logic clk,
  input  logic reset_,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 32'd1);

  logic [CW-1:0] cnt_q;

  // clear wins over counting; the count holds at LIMIT rather than wrapping
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_bus_master.sv
// Bus-master cycle controller: turns a one-cycle CPU request into a handshaken
// active-low bus cycle with ok_ acknowledge, read capture and timeout alarm.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        reset_hold,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [3:0]  nb,
  input  logic [15:0] ad,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        alarm,
  output logic [15:0] rdata,
  output logic [3:0]  nb_,
  output logic [15:0] ad_,
  output logic [15:0] rdt_,
  output logic        r_,
  output logic        w_,
  output logic        s_,
  input  logic        ok_,
  input  logic [15:0] ddt_
);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  nb_q, nb_d;
  logic [15:0] ad_q, ad_d;
  logic [15:0] rdt_q, rdt_d;
  logic        r_q, r_d, w_q, w_d, s_q, s_d;
  logic        busy_q, busy_d, done_q, done_d, alarm_q, alarm_d;
  logic        flag_q, flag_d;
  logic [15:0] rdata_q, rdata_d;
  logic        tmo_clear_s, tmo_en_s, tmo_expired_s;

  bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_  (reset_),
    .clear   (tmo_clear_s),
    .en      (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Next-state and registered-output logic; bus lines go back to idle on entry to DONE
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    nb_d        = nb_q;
    ad_d        = ad_q;
    rdt_d       = rdt_q;
    r_d         = r_q;
    w_d         = w_q;
    s_d         = s_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    alarm_d     = 1'b0;
    flag_d      = flag_q;
    rdata_d     = rdata_q;
    tmo_clear_s = 1'b0;
    tmo_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && (op != OP_RSVD) && !reset_hold) begin
          op_d    = op;
          nb_d    = ~nb;
          ad_d    = ~ad;
          rdt_d   = ~wdata;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        tmo_clear_s = 1'b1;
        r_d         = (op_q != OP_READ);
        w_d         = (op_q != OP_WRITE);
        s_d         = (op_q != OP_CFG);
        state_d     = ST_STROBE;
      end
      ST_STROBE: begin
        tmo_en_s = 1'b1;
        if (!ok_) begin
          if (op_q == OP_READ) begin
            rdata_d = ~ddt_;
          end else begin
            rdata_d = rdata_q;
          end
          {r_d, w_d, s_d} = 3'b111;
          tmo_clear_s     = 1'b1;
          state_d         = ST_RELEASE;
        end else if (tmo_expired_s) begin
          {r_d, w_d, s_d} = 3'b111;
          flag_d          = 1'b1;
          tmo_clear_s     = 1'b1;
          state_d         = ST_RELEASE;
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_RELEASE: begin
        tmo_en_s = 1'b1;
        if (ok_ || tmo_expired_s) begin
          done_d  = 1'b1;
          alarm_d = flag_q || !ok_;
          flag_d  = 1'b0;
          nb_d    = 4'hF;
          ad_d    = 16'hFFFF;
          rdt_d   = 16'hFFFF;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the bus at all-ones
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      nb_q    <= 4'hF;
      ad_q    <= 16'hFFFF;
      rdt_q   <= 16'hFFFF;
      r_q     <= 1'b1;
      w_q     <= 1'b1;
      s_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      flag_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      nb_q    <= nb_d;
      ad_q    <= ad_d;
      rdt_q   <= rdt_d;
      r_q     <= r_d;
      w_q     <= w_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      flag_q  <= flag_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign alarm = alarm_q;
  assign rdata = rdata_q;
  assign nb_   = nb_q;
  assign ad_   = ad_q;
  assign rdt_  = rdt_q;
  assign r_    = r_q;
  assign w_    = w_q;
  assign s_    = s_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a scoreboard of expected completions
// (read data, alarm, done latency, strobe length) popped on each done pulse.
module tb_mem_bus_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset_, reset_hold, req;
  logic [1:0]  op;
  logic [3:0]  nb;
  logic [15:0] ad, wdata;
  logic        busy, done, alarm;
  logic [15:0] rdata;
  logic [3:0]  nb_;
  logic [15:0] ad_, rdt_;
  logic        r_, w_, s_;
  logic        ok_;
  logic [15:0] ddt_;

  typedef struct {
    string       tag;
    logic [15:0] rdata;
    logic        alarm;
    int          done_edge;
    int          strobes;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   strobe_total = 0;
  int   done_total   = 0;
  int   c0, s0, d0;

  mem_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_(reset_), .reset_hold(reset_hold), .req(req), .op(op),
    .nb(nb), .ad(ad), .wdata(wdata), .busy(busy), .done(done), .alarm(alarm),
    .rdata(rdata), .nb_(nb_), .ad_(ad_), .rdt_(rdt_), .r_(r_), .w_(w_), .s_(s_),
    .ok_(ok_), .ddt_(ddt_)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((r_ & w_ & s_) == 1'b0) strobe_total <= strobe_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0: return r_;
      1: return w_;
      2: return s_;
      3: return done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_level(input string tag, input int sel, input logic lvl, input int max_cyc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (pick(sel) === lvl) begin
        hit = 1'b1;
        break;
      end
    end
    check({tag, "_wait"}, {63'd0, hit}, 64'd1);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_bus"}, {25'd0, nb_, ad_, rdt_, r_, w_, s_}, {25'd0, 39'h7F_FFFF_FFFF});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  // called at a negedge with no cycle in flight; returns #1 after the accepting edge
  task automatic start_txn(input string tag, input logic [1:0] o, input logic [3:0] n,
                           input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] e_rd, input logic e_al,
                           input int e_edge, input int e_strb);
    exp_t e;
    req = 1'b1; op = o; nb = n; ad = a; wdata = wd;
    e.tag = tag; e.rdata = e_rd; e.alarm = e_al; e.done_edge = e_edge; e.strobes = e_strb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    c0 = cyc;
    s0 = strobe_total;
    req = 1'b0;
  endtask

  // waits for done, compares against the scoreboard head, then checks the return to IDLE
  task automatic finish_txn(input logic req_in_done);
    exp_t e;
    int   ed;
    wait_level("done", 3, 1'b1, 40);
    ed = cyc - c0 + 1;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_edge"}, 64'(ed), 64'(e.done_edge));
      check({e.tag, "_alarm"}, {63'd0, alarm}, {63'd0, e.alarm});
      check({e.tag, "_rdata"}, {48'd0, rdata}, {48'd0, e.rdata});
      check({e.tag, "_strobes"}, 64'(strobe_total - s0), 64'(e.strobes));
      check({e.tag, "_bus_done"}, {25'd0, nb_, ad_, rdt_, r_, w_, s_}, {25'd0, 39'h7F_FFFF_FFFF});
    end
    if (req_in_done) begin
      req = 1'b1; op = 2'd0;
    end
    @(negedge clk);
    req = 1'b0;
    check("done_single", {62'd0, done, alarm}, 64'd0);
    check("busy_drop", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset_ = 1'b0; reset_hold = 1'b0; req = 1'b0; op = 2'd0; nb = 4'h0;
    ad = 16'h0000; wdata = 16'h0000; ok_ = 1'b1; ddt_ = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_idle_bus("reset");
    check("reset_flags", {62'd0, done, alarm}, 64'd0);
    check("reset_rdata", {48'd0, rdata}, 64'd0);
    reset_ = 1'b1;
    @(negedge clk);

    // read with SRAM-like ok_ two cycles after r_ falls
    ddt_ = ~16'hBEEF;
    start_txn("read", 2'd0, 4'h0, 16'h1234, 16'h0000, 16'hBEEF, 1'b0, 7, 3);
    wait_level("read_r_low", 0, 1'b0, 10);
    check("read_busy", {63'd0, busy}, 64'd1);
    check("read_addr", {44'd0, nb_, ad_}, {44'd0, 4'hF, 16'hEDCB});
    @(posedge clk); @(posedge clk); #1 ok_ = 1'b0;
    wait_level("read_r_high", 0, 1'b1, 10);
    @(posedge clk); #1 ok_ = 1'b1;
    finish_txn(1'b0);

    // write: data and address visible while w_ is low
    start_txn("write", 2'd1, 4'h3, 16'h0042, 16'h5A5A, 16'hBEEF, 1'b0, 6, 2);
    wait_level("write_w_low", 1, 1'b0, 10);
    check("write_rdt", {48'd0, rdt_}, {48'd0, 16'hA5A5});
    check("write_ad", {44'd0, nb_, ad_}, {44'd0, 4'hC, 16'hFFBD});
    check("write_other_strobes", {62'd0, r_, s_}, 64'd3);
    @(posedge clk); #1 ok_ = 1'b0;
    wait_level("write_w_high", 1, 1'b1, 10);
    @(posedge clk); #1 ok_ = 1'b1;
    finish_txn(1'b0);

    // config acknowledged in the same cycle s_ is low; a req in DONE must be dropped
    start_txn("cfg", 2'd2, 4'h1, 16'h0001, 16'h00FF, 16'hBEEF, 1'b0, 4, 1);
    wait_level("cfg_s_low", 2, 1'b0, 10);
    ok_ = 1'b0;
    @(negedge clk);
    check("cfg_s_one_cycle", {63'd0, s_}, 64'd1);
    ok_ = 1'b1;
    finish_txn(1'b1);

    // unmapped page, issued back-to-back: no ok_ at all
    start_txn("unmapped", 2'd0, 4'h7, 16'hF000, 16'h0000, 16'hBEEF, 1'b1, TMO + 3, TMO);
    finish_txn(1'b0);

    // ok_ lands on the very edge the strobe limit is reached: success
    ddt_ = ~16'h1357;
    start_txn("simult", 2'd0, 4'h2, 16'h0100, 16'h0000, 16'h1357, 1'b0, TMO + 3, TMO);
    repeat (TMO) @(posedge clk);
    #1 ok_ = 1'b0;
    wait_level("simult_r_high", 0, 1'b1, 10);
    ok_ = 1'b1;
    finish_txn(1'b0);

    // ok_ stuck low: early ok_ in SETUP ignored, capture in STROBE, release times out
    ddt_ = ~16'h0F0F;
    ok_ = 1'b0;
    start_txn("stuck_ok", 2'd0, 4'h4, 16'h0200, 16'h0000, 16'h0F0F, 1'b1, TMO + 3, 1);
    finish_txn(1'b0);
    ok_ = 1'b1;

    // reserved op and reset_hold both drop the request
    req = 1'b1; op = 2'd3;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    check_idle_bus("op3_drop");
    req = 1'b1; op = 2'd0; reset_hold = 1'b1;
    @(posedge clk); #1 req = 1'b0; reset_hold = 1'b0;
    @(negedge clk);
    check_idle_bus("hold_drop");

    // reset in the middle of a write strobe
    req = 1'b1; op = 2'd1; ad = 16'h00AA; wdata = 16'h1111;
    @(posedge clk); #1 req = 1'b0;
    wait_level("rst_w_low", 1, 1'b0, 10);
    reset_ = 1'b0;
    #1;
    check_idle_bus("rst_mid");
    check("rst_mid_rdata", {48'd0, rdata}, 64'd0);
    d0 = done_total;
    @(negedge clk);
    reset_ = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_done", 64'(done_total - d0), 64'd0);
    check_idle_bus("rst_after");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus-master cycle controller between the CPU micro-sequencer and the memory modules on the system bus. It turns a single-cycle CPU request (read, write, or configuration set) into a fully handshaken active-low bus cycle on `nb_`, `ad_`, `rdt_`, `r_`, `w_` and `s_`. It waits for `ok_`, captures read data from `ddt_`, and enforces a no-answer timeout that raises `alarm` when a page is unmapped or no module responds. It sits directly upstream of the SRAM memory module and drives the lines that module consumes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32: strobe cycles allowed without `ok_` before the cycle is aborted with `alarm`. Legal range is 4..255.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_`  in  1  asynchronous, active-low reset.
- `reset_hold`  in  1  from memory; while high, no new cycle starts.
- `req`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  operation: 0 = read, 1 = write, 2 = config (`s_`); 3 is ignored.
- `nb`  in  4  block number, active-high.
- `ad`  in  16  address, active-high, bit 0 = MSB.
- `wdata`  in  16  write or config data, active-high.
- `busy`  out  1  high from acceptance until after `done`.
- `done`  out  1  one-cycle pulse when the cycle completes.
- `alarm`  out  1  one-cycle pulse coincident with `done` on timeout.
- `rdata`  out  16  captured read data; held until the next read completes.
- `nb_`, `ad_`, `rdt_`  out  4/16/16  bus lines, active-low, registered.
- `r_`, `w_`, `s_`  out  1  bus strobes, active-low, registered.
- `ok_`  in  1  bus acknowledge, active-low.
- `ddt_`  in  16  bus read data, active-low.

## Operation
- States are IDLE, SETUP, STROBE, RELEASE and DONE.
- **IDLE**
  - `req` with `op` in {0, 1, 2} and `reset_hold` = 0 is accepted: `nb`, `ad` and `wdata` are registered, and the block moves to SETUP.
  - `req` with `op` = 3, or while `reset_hold` = 1, is dropped. No pulse is generated.
- **SETUP**: `nb_ = ~nb`, `ad_ = ~ad`, `rdt_ = ~wdata` are driven with all strobes high. The block spends one cycle here, then moves to STROBE.
- **STROBE**
  - The selected strobe is low: `r_` for read, `w_` for write, `s_` for config.
  - The timeout counter clears on entry and increments each cycle.
  - If `ok_` is sampled low:
    - for a read, `rdata <= ~ddt_` is captured on that same edge;
    - the strobe deasserts;
    - the block moves to RELEASE.
  - If the counter reaches `TIMEOUT_CYCLES - 1` with `ok_` still high:
    - the strobe deasserts;
    - the alarm flag is set;
    - the block moves to RELEASE.
- **RELEASE**
  - Strobes are high and address/data are still driven.
  - The block waits for `ok_` high, then moves to DONE.
  - This wait is bounded by the same timeout, restarted. On expiry the block moves to DONE with alarm set.
- **DONE**
  - `done` is pulsed, plus `alarm` if the flag is set.
  - All bus lines return to all-ones and the alarm flag clears.
  - The block moves to IDLE. `busy` drops on that transition.
- Arithmetic: the counter is `$clog2(TIMEOUT_CYCLES)` bits and saturates; it never wraps.
- `ok_` arriving in SETUP or IDLE is ignored.

## Timing
- **Reset** (`reset_` low, immediate and asynchronous):
  - state = IDLE;
  - all bus outputs (`nb_`, `ad_`, `rdt_`, `r_`, `w_`, `s_`) = all ones;
  - `busy`, `done`, `alarm` = 0;
  - `rdata` = 0;
  - counter = 0.
- **Reset mid-cycle**: strobes release asynchronously and no `done` is issued.
- **Minimum cycle**: `req` at edge 0, SETUP at 1, STROBE at 2. The SRAM module returns `ok_` two edges later. RELEASE follows, then DONE.
  - A read therefore completes in 7 edges from `req` to `done`.
- **Back-to-back**: a new `req` is accepted the cycle after `done`. The `req` presented in the DONE cycle is dropped.
- **Simultaneous events**: `ok_` low on the same edge the counter hits its limit is treated as success; `alarm` stays 0.
- **Timeout cycle**: `done`/`alarm` arrive `TIMEOUT_CYCLES + 3` edges after `req` when `ok_` never asserts.
- **`reset_hold`** is checked only at acceptance. Assertion mid-cycle does not abort the cycle.

## Structure
- Package `mem_bus_pkg` holds:
  - `op` codes `OP_READ`, `OP_WRITE`, `OP_CFG`;
  - the state enum;
  - the default `TIMEOUT_CYCLES`.
- Sub-module `bus_timeout` is a saturating counter with `clear`, `en`, and an `expired` output. It is instantiated once and reused for the STROBE and RELEASE waits.
- Everything else is one FSM with registered bus outputs.

## Test plan
- **Read**: `op` = 0, `nb` = 0, `ad` = 0x1234; model drives `ddt_` = ~0xBEEF and `ok_` low 2 cycles after `r_` falls → `rdata` = 0xBEEF, `done` at edge 7, `alarm` = 0.
- **Write**: `op` = 1, `ad` = 0x0042, `wdata` = 0x5A5A → `rdt_` = 0xA5A5 and `ad_` = 0xFFBD while `w_` is low; `done` pulses once.
- **Config**: `op` = 2; model gives `ok_` in the same cycle `s_` is low → `s_` low for exactly 1 cycle, `done` with no `alarm`.
- **Unmapped page**: `ok_` never asserts, `TIMEOUT_CYCLES` = 8 → strobe low for exactly 8 cycles, then `done` and `alarm` pulse together at edge 11; `rdata` unchanged.
- **Reset mid-strobe**: `reset_` low during STROBE → `r_`/`w_`/`s_` go high immediately, all outputs at reset values, and no `done` is issued.
- **`reset_hold` = 1 with `req`**: the request is dropped, `busy` stays 0, and bus lines stay all ones.
